muldiv_ctrl: RTL

//  Multi-cycle multiply/divide unit with its HI/LO register pair for the MIPS EX stage, beside the ALU.

---
 rtl/muldiv_pkg.sv | 26 ++
 rtl/muldiv_if.sv | 13 +
 rtl/muldiv_arith.sv | 58 +++++
 rtl/muldiv_ctrl.sv | 129 ++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, FSM states and
// op classification helpers.
package muldiv_pkg;

  localparam logic [2:0] MD_MULT  = 3'b000;
  localparam logic [2:0] MD_MULTU = 3'b001;
  localparam logic [2:0] MD_DIV   = 3'b010;
  localparam logic [2:0] MD_DIVU  = 3'b011;
  localparam logic [2:0] MD_MTHI  = 3'b100;
  localparam logic [2:0] MD_MTLO  = 3'b101;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } md_state_e;

  // mult/multu/div/divu all share op[2] == 0
  function automatic logic is_long_op(input logic [2:0] op);
    return (op[2] == 1'b0);
  endfunction

  function automatic logic is_mul_op(input logic [2:0] op);
    return (op[2:1] == 2'b00);
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// Issue/result bundle between the EX stage and the multiply/divide unit.
interface muldiv_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (output start, op, A, B, input busy, HI, LO);
  modport slave  (input start, op, A, B, output busy, HI, LO);
endinterface

// File: rtl/muldiv_arith.sv
// Combinational 64-bit {hi,lo} result for the latched operands; o_wr is low
// when HI/LO must be left untouched (divide by zero, non-arith op).
module muldiv_arith
  import muldiv_pkg::*;
(
  input  logic [2:0]  i_op,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [31:0] o_hi,
  output logic [31:0] o_lo,
  output logic        o_wr
);

  logic [63:0] w_prod_s;
  logic [63:0] w_prod_u;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic [31:0] w_den_s;
  logic [31:0] w_den_u;
  logic [31:0] w_uq_s;
  logic [31:0] w_ur_s;
  logic [31:0] w_q_s;
  logic [31:0] w_r_s;
  logic [31:0] w_q_u;
  logic [31:0] w_r_u;
  logic        w_b_zero;

  assign w_prod_s = {{32{i_a[31]}}, i_a} * {{32{i_b[31]}}, i_b};
  assign w_prod_u = {32'd0, i_a} * {32'd0, i_b};

  // Signed divide runs on magnitudes; 0x80000000/-1 falls out as 0x80000000 r 0
  assign w_a_mag  = i_a[31] ? (32'd0 - i_a) : i_a;
  assign w_b_mag  = i_b[31] ? (32'd0 - i_b) : i_b;
  assign w_b_zero = (i_b == 32'd0);
  assign w_den_s  = w_b_zero ? 32'd1 : w_b_mag;
  assign w_den_u  = w_b_zero ? 32'd1 : i_b;

  assign w_uq_s = w_a_mag / w_den_s;
  assign w_ur_s = w_a_mag % w_den_s;
  assign w_q_s  = (i_a[31] ^ i_b[31]) ? (32'd0 - w_uq_s) : w_uq_s;
  assign w_r_s  = i_a[31] ? (32'd0 - w_ur_s) : w_ur_s;
  assign w_q_u  = i_a / w_den_u;
  assign w_r_u  = i_a % w_den_u;

  always_comb begin
    o_hi = 32'd0;
    o_lo = 32'd0;
    o_wr = 1'b0;
    case (i_op)
      MD_MULT:  begin {o_hi, o_lo} = w_prod_s; o_wr = 1'b1; end
      MD_MULTU: begin {o_hi, o_lo} = w_prod_u; o_wr = 1'b1; end
      MD_DIV:   begin o_hi = w_r_s; o_lo = w_q_s; o_wr = !w_b_zero; end
      MD_DIVU:  begin o_hi = w_r_u; o_lo = w_q_u; o_wr = !w_b_zero; end
      default:  begin o_hi = 32'd0; o_lo = 32'd0; o_wr = 1'b0; end
    endcase
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// Multiply/divide controller: IDLE/RUN FSM, latency counter, operand latches
// and the architectural HI/LO pair.
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
)(
  input  logic     clk,
  input  logic     reset,
  muldiv_if.slave  bus
);

  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

  md_state_e        r_state;
  md_state_e        w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [31:0]      r_a;
  logic [31:0]      r_b;
  logic [2:0]       r_op;
  logic             w_latch;
  logic [31:0]      r_hi;
  logic [31:0]      r_lo;
  logic [31:0]      w_hi_nxt;
  logic [31:0]      w_lo_nxt;
  logic             r_busy;
  logic             w_issue;
  logic [31:0]      w_ar_hi;
  logic [31:0]      w_ar_lo;
  logic             w_ar_wr;

  assign w_issue = bus.start && is_long_op(bus.op);

  muldiv_arith u_arith (
    .i_op (r_op),
    .i_a  (r_a),
    .i_b  (r_b),
    .o_hi (w_ar_hi),
    .o_lo (w_ar_lo),
    .o_wr (w_ar_wr)
  );

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_a     <= 32'd0;
      r_b     <= 32'd0;
      r_op    <= 3'b000;
      r_hi    <= 32'd0;
      r_lo    <= 32'd0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_hi    <= w_hi_nxt;
      r_lo    <= w_lo_nxt;
      r_busy  <= (w_state_nxt == S_RUN);
      if (w_latch) begin
        r_a  <= bus.A;
        r_b  <= bus.B;
        r_op <= bus.op;
      end
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_issue) w_state_nxt = S_RUN;
        else         w_state_nxt = S_IDLE;
      end
      S_RUN: begin
        if (r_cnt == '0) w_state_nxt = S_IDLE;
        else             w_state_nxt = S_RUN;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Counter, operand latch and HI/LO update; start is only honoured in IDLE
  always_comb begin
    w_cnt_nxt = r_cnt;
    w_latch   = 1'b0;
    w_hi_nxt  = r_hi;
    w_lo_nxt  = r_lo;
    case (r_state)
      S_IDLE: begin
        if (w_issue) begin
          w_latch   = 1'b1;
          w_cnt_nxt = is_mul_op(bus.op) ? MUL_LOAD : DIV_LOAD;
        end else if (bus.start && (bus.op == MD_MTHI)) begin
          w_hi_nxt = bus.A;
        end else if (bus.start && (bus.op == MD_MTLO)) begin
          w_lo_nxt = bus.A;
        end else begin
          w_cnt_nxt = r_cnt;
        end
      end
      S_RUN: begin
        if (r_cnt == '0) begin
          if (w_ar_wr) begin
            w_hi_nxt = w_ar_hi;
            w_lo_nxt = w_ar_lo;
          end else begin
            w_hi_nxt = r_hi;
            w_lo_nxt = r_lo;
          end
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      default: w_cnt_nxt = '0;
    endcase
  end

  assign bus.busy = r_busy;
  assign bus.HI   = r_hi;
  assign bus.LO   = r_lo;

endmodule
